// File: rtl/ad_ip_jesd204_tpl_dac_hop_ctrl.sv
// ============================================================================
// ad_ip_jesd204_tpl_dac_hop_ctrl
//
// Frequency-hop sequencer and write-bus arbiter placed between the AXI-to-up
// bridge and the up bus of the JESD204 TPL DAC register map.
//
// Host reads are a zero-latency combinational pass-through. Host writes share
// the register-map write port with an internal sequencer. On hop_trigger, the
// sequencer does three things in order:
//   1. writes one hop-table word into the DDS increment register of each
//      channel;
//   2. writes SYNC_DATA to SYNC_ADDR, so that every channel retunes on the
//      same cycle;
//   3. advances hop_index.
//
// Ports
//   up_clk, up_rstn              clock, asynchronous active-low reset
//   up_wreq_s/_waddr_s/_wdata_s  host write request (1-cycle pulse)
//   up_wack_s                    host write ack pulse
//   up_rreq_s/_raddr_s           host read request -> m_rreq/m_raddr
//   up_rdata_s/_rack_s           host read data/ack <- m_rdata/m_rack
//   m_wreq/m_waddr/m_wdata       write request to the register map
//   m_wack                       register-map write ack
//   m_rreq/m_raddr               read request to the register map
//   m_rdata/m_rack               register-map read data and ack
//   tbl_wr/tbl_addr/tbl_data     hop-table load (index = hop*NUM_CHANNELS+ch)
//   hop_trigger                  start-hop pulse
//   hop_status_clr               clears hop_overrun and hop_timeout
//   hop_busy                     hop sequence in progress
//   hop_done                     1-cycle pulse when a hop completes
//   hop_index                    hop applied by the next trigger
//   hop_overrun                  sticky: trigger arrived while busy
//   hop_timeout                  sticky: a write ack timed out
// ============================================================================
module ad_ip_jesd204_tpl_dac_hop_ctrl #(
    parameter int          NUM_CHANNELS    = 2,
    parameter int          NUM_HOPS        = 4,
    parameter logic [10:0] CHAN_BASE_ADDR  = 11'h100,
    parameter logic [3:0]  INCR_REG_OFFSET = 4'h1,
    parameter logic [10:0] SYNC_ADDR       = 11'h011,
    parameter logic [31:0] SYNC_DATA       = 32'h1,
    parameter int          TIMEOUT_CYCLES  = 255,
    localparam int         TBL_DEPTH       = NUM_HOPS * NUM_CHANNELS,
    localparam int         TBL_AW          = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1,
    localparam int         HOP_W           = $clog2(NUM_HOPS)
) (
    input  logic              up_clk,
    input  logic              up_rstn,

    input  logic              up_wreq_s,
    input  logic [10:0]       up_waddr_s,
    input  logic [31:0]       up_wdata_s,
    output logic              up_wack_s,
    input  logic              up_rreq_s,
    input  logic [10:0]       up_raddr_s,
    output logic [31:0]       up_rdata_s,
    output logic              up_rack_s,

    output logic              m_wreq,
    output logic [10:0]       m_waddr,
    output logic [31:0]       m_wdata,
    input  logic              m_wack,
    output logic              m_rreq,
    output logic [10:0]       m_raddr,
    input  logic [31:0]       m_rdata,
    input  logic              m_rack,

    input  logic              tbl_wr,
    input  logic [TBL_AW-1:0] tbl_addr,
    input  logic [31:0]       tbl_data,

    input  logic              hop_trigger,
    input  logic              hop_status_clr,
    output logic              hop_busy,
    output logic              hop_done,
    output logic [HOP_W-1:0]  hop_index,
    output logic              hop_overrun,
    output logic              hop_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_CH     = 3'd1,
        S_WAIT_CH   = 3'd2,
        S_WR_SYNC   = 3'd3,
        S_WAIT_SYNC = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_SEQ  = 2'd2
    } owner_t;

    // The last cycle an owner may hold the bus before it is forcibly released.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] CH_LAST  = 4'(NUM_CHANNELS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [3:0]         ch_q, ch_d;
    logic [HOP_W-1:0]   hop_index_q, hop_index_d;

    owner_t             owner_q, owner_d;
    logic               pend_q, pend_d;
    logic [10:0]        pend_addr_q, pend_addr_d;
    logic [31:0]        pend_data_q, pend_data_d;

    logic               m_wreq_q, m_wreq_d;
    logic [10:0]        m_waddr_q, m_waddr_d;
    logic [31:0]        m_wdata_q, m_wdata_d;
    logic               up_wack_q, up_wack_d;
    logic [7:0]         tmo_cnt_q, tmo_cnt_d;

    logic               overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    logic               hop_busy_c;
    logic               hop_done_c;

    // Hop table; not reset, contents are owned by the loader.
    logic [31:0]        tbl_mem [TBL_DEPTH];

    // ------------------------------------------------------------------------
    // Arbitration terms
    // ------------------------------------------------------------------------
    logic               host_valid;
    logic [10:0]        host_addr;
    logic [31:0]        host_data;
    logic               bus_free;
    logic               seq_req;
    logic               host_grant;
    logic               seq_grant;
    logic               wr_ack;
    logic               wr_expire;
    logic               seq_ack;
    logic               seq_expire;
    logic [TBL_AW-1:0]  tbl_rd_idx;
    logic [10:0]        chan_addr;
    logic [10:0]        seq_addr;
    logic [31:0]        seq_data;

    // A fresh up_wreq_s may be issued on the same edge it arrives, which is
    // what keeps the host-side write latency at one cycle. Otherwise it waits
    // in the one-deep pending register. The bridge never overlaps requests,
    // so both sources are never active at once.
    assign host_valid = pend_q | up_wreq_s;
    assign host_addr  = pend_q ? pend_addr_q : up_waddr_s;
    assign host_data  = pend_q ? pend_data_q : up_wdata_s;

    assign bus_free   = (owner_q == OWN_NONE);
    assign seq_req    = (state_q == S_WR_CH) || (state_q == S_WR_SYNC);
    assign host_grant = bus_free && host_valid;
    assign seq_grant  = bus_free && !host_valid && seq_req;

    // Acks that arrive while nobody owns the bus are stale and ignored.
    assign wr_ack     = (owner_q != OWN_NONE) && m_wack;
    assign wr_expire  = (owner_q != OWN_NONE) && !m_wack && (tmo_cnt_q == TMO_LAST);
    assign seq_ack    = (owner_q == OWN_SEQ) && m_wack;
    assign seq_expire = (owner_q == OWN_SEQ) && wr_expire;

    assign tbl_rd_idx = TBL_AW'(int'(hop_index_q) * NUM_CHANNELS + int'(ch_q));
    assign chan_addr  = CHAN_BASE_ADDR + {3'b000, ch_q, 4'b0000} + {7'b0000000, INCR_REG_OFFSET};
    assign seq_addr   = (state_q == S_WR_CH) ? chan_addr : SYNC_ADDR;
    // The table word is sampled into m_wdata at grant time, so a table update
    // only affects entries that have not been granted yet.
    assign seq_data   = (state_q == S_WR_CH) ? tbl_mem[tbl_rd_idx] : SYNC_DATA;

    // ------------------------------------------------------------------------
    // Write-port arbiter and timeout counter
    // ------------------------------------------------------------------------
    always_comb begin
        owner_d     = owner_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        m_wreq_d    = 1'b0;
        m_waddr_d   = m_waddr_q;
        m_wdata_d   = m_wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        // The host is acked even on timeout so that the bridge can never hang.
        up_wack_d   = (owner_q == OWN_HOST) && (wr_ack || wr_expire);

        if (owner_q != OWN_NONE) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end

        if (wr_ack || wr_expire) begin
            owner_d = OWN_NONE;
        end

        if (up_wreq_s && !host_grant) begin
            pend_d      = 1'b1;
            pend_addr_d = up_waddr_s;
            pend_data_d = up_wdata_s;
        end

        if (host_grant) begin
            m_wreq_d  = 1'b1;
            m_waddr_d = host_addr;
            m_wdata_d = host_data;
            owner_d   = OWN_HOST;
            tmo_cnt_d = 8'd0;
            pend_d    = 1'b0;
        end else if (seq_grant) begin
            m_wreq_d  = 1'b1;
            m_waddr_d = seq_addr;
            m_wdata_d = seq_data;
            owner_d   = OWN_SEQ;
            tmo_cnt_d = 8'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Hop sequencer FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        hop_index_d = hop_index_q;
        hop_busy_c  = (state_q != S_IDLE);
        hop_done_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (hop_trigger) begin
                    state_d = S_WR_CH;
                    ch_d    = 4'd0;
                end
            end
            S_WR_CH: begin
                if (seq_grant) begin
                    state_d = S_WAIT_CH;
                end
            end
            S_WAIT_CH: begin
                if (seq_ack) begin
                    if (ch_q == CH_LAST) begin
                        state_d = S_WR_SYNC;
                    end else begin
                        ch_d    = ch_q + 4'd1;
                        state_d = S_WR_CH;
                    end
                end else if (seq_expire) begin
                    // Abandon the hop; hop_index stays so it can be retried.
                    state_d = S_IDLE;
                end
            end
            S_WR_SYNC: begin
                if (seq_grant) begin
                    state_d = S_WAIT_SYNC;
                end
            end
            S_WAIT_SYNC: begin
                if (seq_ack) begin
                    state_d = S_DONE;
                end else if (seq_expire) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                hop_done_c  = 1'b1;
                hop_index_d = hop_index_q + HOP_W'(1);
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky status: a set in the same cycle as a clear wins.
    always_comb begin
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (hop_status_clr) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
        if (hop_trigger && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end
        if (wr_expire) begin
            timeout_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            state_q     <= S_IDLE;
            ch_q        <= 4'd0;
            hop_index_q <= '0;
            owner_q     <= OWN_NONE;
            pend_q      <= 1'b0;
            pend_addr_q <= 11'd0;
            pend_data_q <= 32'd0;
            m_wreq_q    <= 1'b0;
            m_waddr_q   <= 11'd0;
            m_wdata_q   <= 32'd0;
            up_wack_q   <= 1'b0;
            tmo_cnt_q   <= 8'd0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            hop_index_q <= hop_index_d;
            owner_q     <= owner_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            m_wreq_q    <= m_wreq_d;
            m_waddr_q   <= m_waddr_d;
            m_wdata_q   <= m_wdata_d;
            up_wack_q   <= up_wack_d;
            tmo_cnt_q   <= tmo_cnt_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    always_ff @(posedge up_clk) begin
        if (tbl_wr) begin
            tbl_mem[tbl_addr] <= tbl_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign m_wreq      = m_wreq_q;
    assign m_waddr     = m_waddr_q;
    assign m_wdata     = m_wdata_q;
    assign up_wack_s   = up_wack_q;

    assign m_rreq      = up_rreq_s;
    assign m_raddr     = up_raddr_s;
    assign up_rdata_s  = m_rdata;
    assign up_rack_s   = m_rack;

    assign hop_busy    = hop_busy_c;
    assign hop_done    = hop_done_c;
    assign hop_index   = hop_index_q;
    assign hop_overrun = overrun_q;
    assign hop_timeout = timeout_q;

endmodule

// File: doc/ad_ip_jesd204_tpl_dac_hop_ctrl.md
# ad_ip_jesd204_tpl_dac_hop_ctrl

Frequency-hop sequencer and write-bus arbiter for the JESD204 DAC transport-layer register map. It sits between the AXI-to-up bridge and the TPL DAC register map's up bus. Host reads pass straight through, and host writes share the write port with an internal sequencer. On each trigger, the sequencer writes one hop-table word per channel into the channel DDS registers, then writes the common sync register so that all channels retune together.

## Interface
- NUM_CHANNELS, 2: DAC channels updated per hop (1..16).
- NUM_HOPS, 4: hop profiles in the table (power of 2, 2..64).
- CHAN_BASE_ADDR, 11'h100: word address of channel 0 register block; channel ch base = CHAN_BASE_ADDR + 16*ch.
- INCR_REG_OFFSET, 4'h1: register within the channel block that receives the hop word ({init,incr}).
- SYNC_ADDR, 11'h011: common register written to apply a hop.
- SYNC_DATA, 32'h1: data written to SYNC_ADDR.
- TIMEOUT_CYCLES, 255: maximum cycles to wait for a write ack (1..255).
- up_clk  in  1  register-bus clock; sole clock.
- up_rstn  in  1  asynchronous active-low reset.
- up_wreq_s / up_waddr_s / up_wdata_s  in  1/11/32  host write request (single-cycle pulse), address, data.
- up_wack_s  out  1  host write ack pulse.
- up_rreq_s / up_raddr_s  in  1/11  host read request and address; passed through to m_rreq/m_raddr.
- up_rdata_s / up_rack_s  out  32/1  host read data and ack; passed through from m_rdata/m_rack.
- m_wreq / m_waddr / m_wdata  out  1/11/32  write request to the register map.
- m_wack  in  1  register-map write ack.
- m_rreq / m_raddr  out  1/11  read request and address to the register map.
- m_rdata / m_rack  in  32/1  register-map read data and ack.
- tbl_wr / tbl_addr / tbl_data  in  1/$clog2(NUM_HOPS*NUM_CHANNELS)/32  hop-table load; entry index = hop*NUM_CHANNELS + ch.
- hop_trigger  in  1  start-hop pulse.
- hop_status_clr  in  1  clears the sticky flags.
- hop_busy  out  1  sequence in progress.
- hop_done  out  1  one-cycle pulse when a hop completes.
- hop_index  out  $clog2(NUM_HOPS)  hop applied by the next trigger.
- hop_overrun  out  1  sticky; trigger arrived while busy.
- hop_timeout  out  1  sticky; a write ack timed out.

## Operation
- Reset values: every output 0, hop_index 0, owner NONE, no pending host write. The table is not reset.
- Host write capture: up_wreq_s loads a one-deep pending register (addr, data).
  - up_axi holds off the next request until up_wack_s, so overflow cannot occur.
- Write-port owner is NONE, HOST or SEQ.
  - When owner is NONE, a pending host write wins over a sequencer request.
  - Issuing a write pulses m_wreq for 1 cycle and sets owner accordingly.
  - m_wack releases the owner to NONE.
  - For a HOST-owned write, m_wack also causes up_wack_s to pulse on the next cycle.
  - An m_wack received while owner is NONE is ignored.
- Sequencer FSM states: IDLE, WR_CH, WAIT_CH, WR_SYNC, WAIT_SYNC, DONE.
  - IDLE to WR_CH on hop_trigger; ch=0, hop_busy=1.
  - WR_CH requests the write of table[hop_index*NUM_CHANNELS+ch] to CHAN_BASE_ADDR+16*ch+INCR_REG_OFFSET. The table entry is read at grant, then the FSM moves to WAIT_CH.
  - WAIT_CH on ack: if ch==NUM_CHANNELS-1, go to WR_SYNC; otherwise ch++ and return to WR_CH.
  - WR_SYNC writes SYNC_DATA to SYNC_ADDR, then moves to WAIT_SYNC; on ack, go to DONE.
  - DONE (1 cycle): pulse hop_done, hop_index++ (wraps NUM_HOPS-1 to 0), hop_busy=0, return to IDLE.
- Trigger outside IDLE is dropped and sets hop_overrun.
- Timeout: an 8-bit counter runs while owner is not NONE and reloads at each issue. Reaching TIMEOUT_CYCLES without m_wack:
  - sets hop_timeout and releases the owner;
  - for a HOST-owned write, up_wack_s still pulses so the host never hangs;
  - for a SEQ-owned write, the FSM returns to IDLE with no hop_done and hop_index unchanged.
- tbl_wr is accepted in any state; it affects a running hop only for entries not yet granted.
- hop_status_clr clears both flags; a same-cycle set wins.

## Timing
- Host write when the bus is free: up_wreq_s at cycle N, m_wreq at N+1, m_wack at N+1+L, up_wack_s at N+2+L. The block adds one cycle of write latency on each side.
- Sequencer grant: m_wreq 1 cycle after entering WR_* with the bus free; the next request is issued no earlier than the cycle after its ack.
- Hop duration with L-cycle acks and no host traffic: (NUM_CHANNELS+1)*(L+2)+1 cycles from trigger to hop_done.
- Reads: purely combinational pass-through, zero added latency.
- Reset asserted mid-sequence: immediately returns to the reset values above; any pending host write is discarded.

## Test plan
- Table: ch0 = 32'h0000_1000, ch1 = 32'h0000_2000; acks 2 cycles after request; trigger -> writes 0x101 = 32'h1000, then 0x111 = 32'h2000, then 0x011 = 32'h1; hop_done at cycle 13; hop_index = 1.
- 4 consecutive hops with NUM_HOPS=4 -> hop_index sequence 1, 2, 3, 0; the fifth hop uses entries 0..1 again.
- Host write to 0x040 issued in the same cycle the sequencer is in WR_CH with the bus free -> host write issued first, sequencer next; exactly one up_wack_s pulse.
- Trigger while busy -> hop_overrun=1, no extra writes; hop_status_clr -> 0.
- m_wack suppressed on the channel-1 write -> hop_timeout=1 after 255 cycles, FSM in IDLE, no hop_done, hop_index unchanged; a subsequent host write completes normally.
- up_rstn low during WAIT_CH -> all outputs 0 at once; a late m_wack is ignored; the next trigger starts at hop 0.
